// File: rtl/pipe_ctrl.sv
// ============================================================================
//  Module      : pipe_ctrl
//  Description : PC redirect arbitration, bus-stall deferral, hold merging and
//                post-redirect flush bubble. Optional bus-stall watchdog is
//                built when PIPE_CTRL_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int FLUSH_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_jump_req_in,
    input  logic [31:0] ex_jump_addr_in,
    input  logic        ex_hold_req_in,
    input  logic        bus_hold_req_in,
    input  logic        int_req_in,
    input  logic [31:0] int_addr_in,
    output logic        int_ack_out,
    output logic        jump_flag_out,
    output logic [31:0] jump_addr_out,
    output logic [2:0]  hold_flag_out,
    output logic        timeout_out
);

    localparam logic [1:0] c_flush     = 2'(FLUSH_CYCLES);
    localparam logic [2:0] c_hold_none = 3'd0;
    localparam logic [2:0] c_hold_pc   = 3'd1;
    localparam logic [2:0] c_hold_if   = 3'd2;
    localparam logic [2:0] c_hold_id   = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pend_addr;
    logic [1:0]  r_flush_cnt;

    logic        w_issue;
    logic [31:0] w_issue_addr;
    logic        w_ack;
    logic        w_latch;
    logic [31:0] w_latch_addr;
    logic        w_int_ok;
    logic [2:0]  w_hold;

    // A latched redirect outranks everything; interrupts need a quiet execute stage.
    always_comb begin
        w_issue      = 1'b0;
        w_issue_addr = 32'd0;
        w_ack        = 1'b0;
        w_latch      = 1'b0;
        w_latch_addr = 32'd0;
        w_int_ok     = int_req_in && !ex_hold_req_in;
        if (r_state == S_PEND) begin
            if (!bus_hold_req_in) begin
                w_issue      = 1'b1;
                w_issue_addr = r_pend_addr;
            end
        end else if (!bus_hold_req_in) begin
            if (w_int_ok) begin
                w_issue      = 1'b1;
                w_issue_addr = int_addr_in;
                w_ack        = 1'b1;
            end else if (ex_jump_req_in) begin
                w_issue      = 1'b1;
                w_issue_addr = ex_jump_addr_in;
            end
        end else begin
            if (w_int_ok) begin
                w_latch      = 1'b1;
                w_latch_addr = int_addr_in;
                w_ack        = 1'b1;
            end else if (ex_jump_req_in) begin
                w_latch      = 1'b1;
                w_latch_addr = ex_jump_addr_in;
            end
        end
    end

    always_comb begin
        w_hold = c_hold_none;
        if (ex_hold_req_in)
            w_hold = c_hold_id;
        else if (r_state == S_FLUSH)
            w_hold = c_hold_if;
        else if (bus_hold_req_in)
            w_hold = c_hold_pc;
    end

    assign jump_flag_out = rst & w_issue;
    assign jump_addr_out = rst ? w_issue_addr : 32'd0;
    assign int_ack_out   = rst & w_ack;
    assign hold_flag_out = rst ? w_hold : c_hold_none;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pend_addr <= 32'd0;
            r_flush_cnt <= 2'd0;
        end else if (w_issue) begin
            if (c_flush == 2'd0) begin
                r_state     <= S_IDLE;
                r_flush_cnt <= 2'd0;
            end else begin
                r_state     <= S_FLUSH;
                r_flush_cnt <= c_flush;
            end
        end else if (w_latch) begin
            r_state     <= S_PEND;
            r_pend_addr <= w_latch_addr;
            r_flush_cnt <= 2'd0;
        end else if (r_state == S_FLUSH) begin
            if (r_flush_cnt <= 2'd1) begin
                r_state     <= S_IDLE;
                r_flush_cnt <= 2'd0;
            end else begin
                r_flush_cnt <= r_flush_cnt - 2'd1;
            end
        end
    end

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam logic [7:0] c_to_max  = 8'(TIMEOUT_CYCLES);
    localparam logic [7:0] c_to_last = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_to_cnt;

    // Saturates at the limit so a long stall yields exactly one pulse.
    always_ff @(posedge clk) begin
        if (!rst || !bus_hold_req_in)
            r_to_cnt <= 8'd0;
        else if (r_to_cnt != c_to_max)
            r_to_cnt <= r_to_cnt + 8'd1;
    end

    assign timeout_out = rst && bus_hold_req_in && (r_to_cnt == c_to_last);
`else
    // Watchdog not built; the term only keeps the parameter referenced.
    assign timeout_out = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

endmodule

`default_nettype wire
